// File: rtl/seq_unsigned_mult_pkg.sv
// Shared ALU package: FSM state encoding and the default operand width.
package seq_unsigned_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_unsigned_mult.sv
// Sequential shift-and-add multiplier computing A*B + addend, one multiplier bit per cycle.
module seq_unsigned_mult
  import seq_unsigned_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     addend,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      product_q, product_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;

  // Next-state and datapath; the accumulator cannot carry past PW bits.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = multiplicand;
          mplier_d = multiplier;
          acc_d    = PW'(addend);
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + (PW'(mcand_q) << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d = acc_q;
        ovf_d     = |acc_q[PW-1:WIDTH];
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = product_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_unsigned_mult.sv
// Self-checking bench for seq_unsigned_mult against a plain-arithmetic reference.
module tb_seq_unsigned_mult;

  localparam int unsigned W = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   addend;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           overflow;

  int errors;
  int checks;
  int cyc;

  seq_unsigned_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
    return 64'(a) * 64'(b) + 64'(c);
  endfunction

  // One operation; optional noise scrambles inputs and pulses start while busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input bit noise);
    logic [63:0] exp;
    int n;
    bit seen;
    exp = ref_result(a, b, c);
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b; addend = c;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (noise) begin
          multiplicand = W'($urandom);
          multiplier   = W'($urandom);
          addend       = W'($urandom);
          start = (n >= 2 && n <= int'(W) - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    check_eq("latency", 64'(n), 64'(W + 2));
    check_eq("product", 64'(product), exp);
    check_eq("overflow", 64'(overflow), 64'((exp >> W) != 0));
    @(negedge clk);
    check_eq("done_single", 64'(done), 64'd0);
    check_eq("product_hold", 64'(product), exp);
  endtask

  initial begin
    logic [W-1:0] qa[3];
    logic [W-1:0] qb[3];
    logic [W-1:0] qc[3];
    int last_done;
    int wait_n;
    int done_cnt;

    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0;
    multiplicand = '0; multiplier = '0; addend = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_product", 64'(product), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;

    run_op(16'd10, 16'd10, 16'd0, 1'b0);
    run_op(16'd10, 16'd10, 16'd3, 1'b0);
    run_op(16'd4321, 16'd1, 16'd0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'd12345, 16'd1, 16'd0, 1'b0);
    run_op(16'd0, 16'd12345, 16'd0, 1'b0);
    run_op(16'd0, 16'd0, 16'd77, 1'b0);
    run_op(16'd2, 16'h7FFF, 16'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom), 1'b1);
    end

    // Abort mid-operation: no done pulse, outputs cleared.
    @(negedge clk);
    start = 1'b1; multiplicand = 16'd99; multiplier = 16'd99; addend = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_product", 64'(product), 64'd0);
    check_eq("abort_overflow", 64'(overflow), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 3 * int'(W); i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_eq("abort_no_done", 64'(done_cnt), 64'd0);

    // start coincident with rst is ignored.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_eq("start_with_rst", 64'(busy), 64'd0);
    @(negedge clk);
    check_eq("start_with_rst_idle", 64'(busy), 64'd0);

    run_op(16'd300, 16'd300, 16'd9, 1'b0);

    // start held high: back-to-back operations, new operands applied in each done cycle.
    for (int i = 0; i < 3; i++) begin
      qa[i] = W'($urandom); qb[i] = W'($urandom); qc[i] = W'($urandom);
    end
    @(negedge clk);
    start = 1'b1; multiplicand = qa[0]; multiplier = qb[0]; addend = qc[0];
    last_done = -1;
    for (int k = 0; k < 3; k++) begin
      wait_n = 0;
      @(negedge clk);
      while (!done && wait_n < 100) begin
        @(negedge clk);
        wait_n++;
      end
      check_eq("held_done_seen", 64'(done), 64'd1);
      check_eq("held_product", 64'(product), ref_result(qa[k], qb[k], qc[k]));
      if (last_done >= 0) begin
        check_eq("held_spacing", 64'(cyc - last_done), 64'(W + 2));
      end
      last_done = cyc;
      if (k < 2) begin
        multiplicand = qa[k+1]; multiplier = qb[k+1]; addend = qc[k+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (2 * int'(W)) @(negedge clk);
    check_eq("held_final_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_unsigned_mult.md
SEQ_UNSIGNED_MULT -- requirements
Module: seq_unsigned_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port multiplicand  input  WIDTH  unsigned operand A (divisor-side value).
REQ-006 SHALL have port multiplier  input  WIDTH  unsigned operand B (quotient-side value).
REQ-007 SHALL have port addend  input  WIDTH  unsigned value added to A*B (remainder-side value).
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (BUSY or DONE state).
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port product  output  2*WIDTH  registered result A*B + addend.
REQ-011 SHALL have port overflow  output  1  high when product[2*WIDTH-1:WIDTH] is nonzero, i.e. the result does not fit in WIDTH bits.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-013 In IDLE with start=1, SHALL latch multiplicand, multiplier, addend, initialise accumulator to addend zero-extended, clear the bit counter, and move to BUSY.
REQ-014 In BUSY, each cycle SHALL add (multiplicand << counter) to the accumulator when the current multiplier bit is 1, shift the multiplier copy right by 1, and increment the counter.
REQ-015 SHALL leave BUSY for DONE after exactly WIDTH BUSY cycles; no early termination on zero operands.
REQ-016 In DONE, SHALL load product and overflow from the accumulator, assert done for that single cycle, then return to IDLE.
REQ-017 Latency: start sampled at edge N SHALL give done=1 and valid product in the cycle after edge N+WIDTH+1 (WIDTH+2 cycles from start sample to IDLE).
REQ-018 start while busy=1 (BUSY or DONE) SHALL be ignored; latched operands SHALL not change.
REQ-019 start held high continuously SHALL launch a new operation on the first IDLE cycle after each DONE.
REQ-020 product and overflow SHALL hold their last value until the next DONE; inputs changing mid-operation SHALL not affect the result.
REQ-021 Accumulator SHALL be 2*WIDTH bits; the maximum result (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W fits, so no carry beyond 2*WIDTH bits is possible and none SHALL be tracked.
REQ-022 Zero multiplicand or multiplier SHALL yield product = addend with normal latency.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, product=0, overflow=0, and clear the counter, accumulator and operand registers.
REQ-024 rst asserted mid-operation SHALL abort it with no done pulse; start in the same cycle as rst SHALL be ignored.

Structure
REQ-025 The shared ALU package SHALL hold the state enum (IDLE, BUSY, DONE) and the default operand width constant 16.
REQ-026 SHALL be a single module with no sub-module; the counter width is clog2(WIDTH)+1.

Verification
REQ-027 A=10, B=10, addend=0 -> done after WIDTH+2 cycles, product=100, overflow=0.
REQ-028 A=10, B=10, addend=3 -> product=103 (reconstructs the divider's 103/10 case); A=4321, B=1, addend=0 -> 4321.
REQ-029 A=0xFFFF, B=0xFFFF, addend=0xFFFF -> product=0xFFFF0000, overflow=1; A=12345, B=1, addend=0 -> 12345, overflow=0; A=0, B=12345, addend=0 -> 0.
REQ-030 A=2, B=0x7FFF, addend=1 -> 0xFFFF, overflow=0; second start pulses during BUSY -> ignored, exactly one done pulse.
REQ-031 rst pulsed 5 cycles after start -> busy=0, done never pulses, product=0; new start afterwards completes normally.
REQ-032 start held high for 3 operations -> done pulses spaced WIDTH+2 cycles apart, each product correct.
